// File: rtl/ofifo_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module   : ofifo_writeback_if
//  Brief    : OFIFO read port and psum SRAM write port seen by the writeback.
//  Revision : 1.0
// ============================================================================
interface ofifo_writeback_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_W  = 11
);
    logic                     ofifo_valid;
    logic [COL*PSUM_BW-1:0]   ofifo_data;
    logic                     ofifo_rd;
    logic                     mem_cen;
    logic                     mem_wen;
    logic [ADDR_W-1:0]        mem_addr;
    logic [COL*PSUM_BW-1:0]   mem_d;

    // master: the writeback engine; slave: the OFIFO/SRAM side
    modport master (
        input  ofifo_valid, ofifo_data,
        output ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d
    );
    modport slave (
        output ofifo_valid, ofifo_data,
        input  ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d
    );
endinterface
`default_nettype wire

// File: rtl/ofifo_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : ofifo_writeback
//  Brief    : Drains OFIFO vectors into the psum SRAM with optional lane ReLU.
//  Revision : 1.0
// ============================================================================
module ofifo_writeback #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_W  = 11,
    parameter int CNT_W   = 11
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    input  wire  [ADDR_W-1:0]   base_addr,
    input  wire  [CNT_W-1:0]    num_vec,
    input  wire                 relu_en,
    output logic                busy,
    output logic                done,
    ofifo_writeback_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_rd;
    logic [ADDR_W-1:0]        r_base;
    logic [CNT_W-1:0]         r_num;
    logic                     r_relu;
    logic [CNT_W-1:0]         r_rd_cnt;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic [COL*PSUM_BW-1:0]   w_relu;

    assign w_cnt_inc   = r_rd_cnt + CNT_W'(1);
    assign bus.ofifo_rd = w_rd;

    // Pop is purely combinational so the fall-through head is consumed the same cycle.
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_vec == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_rd = bus.ofifo_valid && (r_rd_cnt < r_num);
                if (w_rd && (w_cnt_inc == r_num)) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next != S_IDLE);
            done    <= (w_next == S_DONE);
        end
    end

    for (genvar l = 0; l < COL; l++) begin : g_lane
        assign w_relu[l*PSUM_BW +: PSUM_BW] =
            (r_relu && bus.ofifo_data[l*PSUM_BW + PSUM_BW - 1]) ? '0
                                                                : bus.ofifo_data[l*PSUM_BW +: PSUM_BW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base       <= '0;
            r_num        <= '0;
            r_relu       <= 1'b0;
            r_rd_cnt     <= '0;
            bus.mem_cen  <= 1'b1;
            bus.mem_wen  <= 1'b1;
            bus.mem_addr <= '0;
            bus.mem_d    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_base   <= base_addr;
                r_num    <= num_vec;
                r_relu   <= relu_en;
                r_rd_cnt <= '0;
            end
            // Address arithmetic wraps modulo the SRAM depth by truncation.
            if (w_rd) begin
                r_rd_cnt     <= w_cnt_inc;
                bus.mem_d    <= w_relu;
                bus.mem_addr <= r_base + ADDR_W'(r_rd_cnt);
                bus.mem_cen  <= 1'b0;
                bus.mem_wen  <= 1'b0;
            end else begin
                bus.mem_cen  <= 1'b1;
                bus.mem_wen  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
